// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the set-2 to ASCII translation table
// for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    FRAME_IDLE,
    FRAME_DATA,
    FRAME_PARITY,
    FRAME_STOP
  } frame_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Returns {mapped, ascii}; each entry lists the {unshifted, shifted} pair.
  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code,
                                                input logic       ext,
                                                input logic       shift);
    logic [7:0] lo;
    logic [7:0] hi;
    logic       hit;
    lo  = '0;
    hi  = '0;
    hit = 1'b1;
    if (ext) begin
      hit = (code == 8'h5A);
      lo  = 8'h0D;
      hi  = 8'h0D;
    end else begin
      case (code)
        8'h1C: {lo, hi} = {"a", "A"};
        8'h32: {lo, hi} = {"b", "B"};
        8'h21: {lo, hi} = {"c", "C"};
        8'h23: {lo, hi} = {"d", "D"};
        8'h24: {lo, hi} = {"e", "E"};
        8'h2B: {lo, hi} = {"f", "F"};
        8'h34: {lo, hi} = {"g", "G"};
        8'h33: {lo, hi} = {"h", "H"};
        8'h43: {lo, hi} = {"i", "I"};
        8'h3B: {lo, hi} = {"j", "J"};
        8'h42: {lo, hi} = {"k", "K"};
        8'h4B: {lo, hi} = {"l", "L"};
        8'h3A: {lo, hi} = {"m", "M"};
        8'h31: {lo, hi} = {"n", "N"};
        8'h44: {lo, hi} = {"o", "O"};
        8'h4D: {lo, hi} = {"p", "P"};
        8'h15: {lo, hi} = {"q", "Q"};
        8'h2D: {lo, hi} = {"r", "R"};
        8'h1B: {lo, hi} = {"s", "S"};
        8'h2C: {lo, hi} = {"t", "T"};
        8'h3C: {lo, hi} = {"u", "U"};
        8'h2A: {lo, hi} = {"v", "V"};
        8'h1D: {lo, hi} = {"w", "W"};
        8'h22: {lo, hi} = {"x", "X"};
        8'h35: {lo, hi} = {"y", "Y"};
        8'h1A: {lo, hi} = {"z", "Z"};
        8'h45: {lo, hi} = {"0", ")"};
        8'h16: {lo, hi} = {"1", "!"};
        8'h1E: {lo, hi} = {"2", "@"};
        8'h26: {lo, hi} = {"3", "#"};
        8'h25: {lo, hi} = {"4", "$"};
        8'h2E: {lo, hi} = {"5", "%"};
        8'h36: {lo, hi} = {"6", "^"};
        8'h3D: {lo, hi} = {"7", "&"};
        8'h3E: {lo, hi} = {"8", "*"};
        8'h46: {lo, hi} = {"9", "("};
        8'h4E: {lo, hi} = {"-", "_"};
        8'h55: {lo, hi} = {"=", "+"};
        8'h54: {lo, hi} = {"[", "{"};
        8'h5B: {lo, hi} = {"]", "}"};
        8'h4C: {lo, hi} = {";", ":"};
        8'h52: {lo, hi} = {"'", "\""};
        8'h41: {lo, hi} = {",", "<"};
        8'h49: {lo, hi} = {".", ">"};
        8'h4A: {lo, hi} = {"/", "?"};
        8'h5D: {lo, hi} = {"\\", "|"};
        8'h29: {lo, hi} = {8'h20, 8'h20};
        8'h5A: {lo, hi} = {8'h0D, 8'h0D};
        8'h66: {lo, hi} = {8'h08, 8'h08};
        default: hit = 1'b0;
      endcase
    end
    return {hit, (shift ? hi : lo)};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_frame.sv
// PS/2 line conditioning and 11-bit frame reception: synchronizers, clock
// glitch filter, mid-frame timeout and the start/data/parity/stop FSM.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]   clk_sync_q, clk_sync_d;
  logic [1:0]   data_sync_q, data_sync_d;
  logic         filt_q, filt_d;
  logic [7:0]   filt_cnt_q, filt_cnt_d;
  logic         filt_prev_q, filt_prev_d;
  logic         strobe;
  logic         data_s;

  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]   scan_code_q, scan_code_d;
  logic         scan_valid_q, scan_valid_d;
  logic         frame_err_q, frame_err_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    filt_prev_d = filt_q;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  // Strobe one cycle after the filtered clock registers low.
  assign strobe = filt_prev_q & ~filt_q;
  assign data_s = data_sync_q[1];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    parity_d     = parity_q;
    to_cnt_d     = '0;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q != FRAME_IDLE && !strobe) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      FRAME_IDLE: begin
        if (strobe) begin
          if (!data_s) begin
            state_d   = FRAME_DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      FRAME_DATA: begin
        if (strobe) begin
          shreg_d   = {data_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = FRAME_PARITY;
          end
        end
      end
      FRAME_PARITY: begin
        if (strobe) begin
          parity_d = data_s;
          state_d  = FRAME_STOP;
        end
      end
      FRAME_STOP: begin
        if (strobe) begin
          if (data_s && ((^shreg_q) ^ parity_q)) begin
            scan_code_d  = shreg_q;
            scan_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = FRAME_IDLE;
        end
      end
      default: state_d = FRAME_IDLE;
    endcase

    if (state_q != FRAME_IDLE && !strobe && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = FRAME_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      filt_prev_q  <= 1'b1;
      state_q      <= FRAME_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      filt_prev_q  <= filt_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: E0/F0/shift decoding, ASCII translation and
// the output FIFO feeding the UART transmit path.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 500,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       shift_held,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0] code_w;
  logic       code_valid_w;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (code_w),
    .scan_valid (code_valid_w),
    .frame_err  (frame_err)
  );

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       shift_held_q, shift_held_d;
  logic       push_q, push_d;
  logic [7:0] push_data_q, push_data_d;
  logic [8:0] lookup;

  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    shift_held_d = shift_held_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    lookup       = scan_to_ascii(code_w, ext_q, shift_held_q);
    if (code_valid_w) begin
      if (code_w == SC_EXT) begin
        ext_d = 1'b1;
      end else if (code_w == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        if (!ext_q && (code_w == SC_LSHIFT || code_w == SC_RSHIFT)) begin
          shift_held_d = !brk_q;
        end else if (!brk_q && lookup[8]) begin
          push_d      = 1'b1;
          push_data_d = lookup[7:0];
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   remain;
  logic [7:0]    out_data_q, out_data_d;
  logic          overflow_q, overflow_d;
  logic          pop;
  logic          push_ok;

  // out_data is a register so it keeps the last byte once the FIFO drains;
  // a push into an otherwise-empty FIFO bypasses the memory.
  always_comb begin
    pop        = (count_q != '0) && out_ready;
    push_ok    = push_q && ((count_q != (AW + 1)'(FIFO_DEPTH)) || pop);
    wr_ptr_d   = wr_ptr_q + AW'(push_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    remain     = count_q - (AW + 1)'(pop);
    count_d    = remain + (AW + 1)'(push_ok);
    overflow_d = push_q && !push_ok;
    out_data_d = out_data_q;
    if (count_d != '0) begin
      out_data_d = (remain == '0) ? push_data_q : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      shift_held_q <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_data_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      shift_held_q <= shift_held_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
    end
  end

  assign scan_code  = code_w;
  assign scan_valid = code_valid_w;
  assign shift_held = shift_held_q;
  assign out_data   = out_data_q;
  assign out_valid  = (count_q != '0);
  assign overflow   = overflow_q;

endmodule
